// File: rtl/dtw_pkt_pkg.sv
// Shared definitions for the DTW result packer: FSM state encoding,
// default frame sync byte and elaboration-time sizing helpers.
package dtw_pkt_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR  = 3'd1,
        S_PAY  = 3'd2,
        S_WAIT = 3'd3,
        S_TRL  = 3'd4,
        S_CSUM = 3'd5
    } pkt_state_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    // Number of payload bytes per result (cost bytes followed by pos bytes).
    function automatic int pkt_nbytes(input int cost_w, input int pos_w, input int dout_w);
        return (cost_w + pos_w) / dout_w;
    endfunction

    // Bits needed to index n payload bytes; never narrower than one bit.
    function automatic int pkt_idx_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/dtw_result_packer.sv
// DTW result packer: accepts per-reference results (cost, end position,
// last flag) and serializes each query into a framed byte stream
//   SYNC_BYTE, {cost LSB-first, pos LSB-first} per result, result count
// written to the output FIFO one byte per cycle, stalling while it is full.
// Optional build macro DTW_PACKER_CHECKSUM_EN appends the XOR of all
// payload bytes of the query after the result-count trailer.
module dtw_result_packer
    import dtw_pkt_pkg::*;
#(
    parameter int                    COST_WIDTH = 32,
    parameter int                    POS_WIDTH  = 16,
    parameter int                    DOUT_WIDTH = 8,
    parameter logic [DOUT_WIDTH-1:0] SYNC_BYTE  = DOUT_WIDTH'(SYNC_BYTE_DEFAULT)
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  res_valid,
    output logic                  res_ready,
    input  logic [COST_WIDTH-1:0] res_cost,
    input  logic [POS_WIDTH-1:0]  res_pos,
    input  logic                  res_last,
    output logic                  dtw_fifo_wren,
    output logic [DOUT_WIDTH-1:0] dtw_fifo_din,
    input  logic                  dtw_fifo_full
);

    localparam int NBYTES = pkt_nbytes(COST_WIDTH, POS_WIDTH, DOUT_WIDTH);
    localparam int IDX_W  = pkt_idx_width(NBYTES);
    localparam int PAY_W  = COST_WIDTH + POS_WIDTH;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    pkt_state_t             state_q;
    logic [IDX_W-1:0]       byte_idx_q;
    logic [7:0]             rcount_q;
    logic [PAY_W-1:0]       payload_q;   // {pos, cost}: byte 0 is cost LSB
    logic                   last_q;
`ifdef DTW_PACKER_CHECKSUM_EN
    logic [DOUT_WIDTH-1:0]  csum_q;
`endif

    logic                   busy;
    logic [DOUT_WIDTH-1:0]  pay_byte;
    logic [DOUT_WIDTH-1:0]  out_byte;

    // Decode handshake, write strobe and the byte presented to the FIFO.
    always_comb begin
        busy     = 1'b0;
        out_byte = '0;
        pay_byte = payload_q[int'(byte_idx_q) * DOUT_WIDTH +: DOUT_WIDTH];
        case (state_q)
            S_HDR: begin
                busy     = 1'b1;
                out_byte = SYNC_BYTE;
            end
            S_PAY: begin
                busy     = 1'b1;
                out_byte = pay_byte;
            end
            S_TRL: begin
                busy     = 1'b1;
                out_byte = DOUT_WIDTH'(rcount_q);
            end
`ifdef DTW_PACKER_CHECKSUM_EN
            S_CSUM: begin
                busy     = 1'b1;
                out_byte = csum_q;
            end
`endif
            default: begin
                busy     = 1'b0;
                out_byte = '0;
            end
        endcase
        res_ready     = (state_q == S_IDLE || state_q == S_WAIT) && !ARESET;
        dtw_fifo_wren = busy && !dtw_fifo_full && !ARESET;
        dtw_fifo_din  = dtw_fifo_wren ? out_byte : '0;
    end

    // Frame FSM: every transition out of a writing state is gated on !full,
    // so a stall simply holds state, index and captured data.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q    <= S_IDLE;
            byte_idx_q <= '0;
            rcount_q   <= '0;
            payload_q  <= '0;
            last_q     <= 1'b0;
`ifdef DTW_PACKER_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (res_valid) begin
                        payload_q <= {res_pos, res_cost};
                        last_q    <= res_last;
                        state_q   <= S_HDR;
                    end
                end
                S_HDR: begin
                    if (!dtw_fifo_full) begin
                        byte_idx_q <= '0;
`ifdef DTW_PACKER_CHECKSUM_EN
                        csum_q     <= '0;
`endif
                        state_q    <= S_PAY;
                    end
                end
                S_PAY: begin
                    if (!dtw_fifo_full) begin
`ifdef DTW_PACKER_CHECKSUM_EN
                        csum_q <= csum_q ^ pay_byte;
`endif
                        if (byte_idx_q == LAST_IDX) begin
                            byte_idx_q <= '0;
                            rcount_q   <= rcount_q + 8'd1;
                            state_q    <= last_q ? S_TRL : S_WAIT;
                        end else begin
                            byte_idx_q <= byte_idx_q + IDX_W'(1);
                        end
                    end
                end
                S_WAIT: begin
                    if (res_valid) begin
                        payload_q  <= {res_pos, res_cost};
                        last_q     <= res_last;
                        byte_idx_q <= '0;
                        state_q    <= S_PAY;
                    end
                end
                S_TRL: begin
                    if (!dtw_fifo_full) begin
                        rcount_q <= '0;
`ifdef DTW_PACKER_CHECKSUM_EN
                        state_q  <= S_CSUM;
`else
                        state_q  <= S_IDLE;
`endif
                    end
                end
`ifdef DTW_PACKER_CHECKSUM_EN
                S_CSUM: begin
                    if (!dtw_fifo_full) begin
                        state_q <= S_IDLE;
                    end
                end
`endif
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dtw_result_packer.sv
// Self-checking bench for dtw_result_packer: a queue-based frame model
// predicts the byte stream and handshake; directed cases pin literal frames.
module tb_dtw_result_packer;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_cost;
    logic [15:0] res_pos;
    logic        res_last;
    logic        dtw_fifo_wren;
    logic [7:0]  dtw_fifo_din;
    logic        dtw_fifo_full;

    always #5 ACLK = ~ACLK;

    dtw_result_packer dut (
        .ACLK          (ACLK),
        .ARESET        (ARESET),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_cost      (res_cost),
        .res_pos       (res_pos),
        .res_last      (res_last),
        .dtw_fifo_wren (dtw_fifo_wren),
        .dtw_fifo_din  (dtw_fifo_din),
        .dtw_fifo_full (dtw_fifo_full)
    );

`ifdef DTW_PACKER_CHECKSUM_EN
    localparam int TAIL = 2;
`else
    localparam int TAIL = 1;
`endif

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // Reference model state
    logic [7:0] exp_q[$];
    logic [7:0] log_q[$];
    int         cyc_q[$];
    bit         q_open   = 0;
    int         q_count  = 0;
    logic [7:0] q_xor    = 0;
    int         accepts  = 0;
    int         stall_cnt = 0;
    int         cyc      = 0;
    bit         full_mode = 0;

    always @(posedge ACLK) cyc++;

    // Random backpressure, only while enabled.
    always @(posedge ACLK) begin
        if (full_mode) begin
            #1 dtw_fifo_full = ($urandom_range(0, 3) == 0);
        end
    end

    // Compare process: sampled on the falling edge, mid-cycle.
    always @(negedge ACLK) begin
        logic [7:0] b;
        if (ARESET) begin
            chk("rst_wren", dtw_fifo_wren, 0);
            chk("rst_din", dtw_fifo_din, 0);
            exp_q.delete();
            q_open  = 0;
            q_count = 0;
        end else begin
            chk("ready", res_ready, exp_q.size() == 0);
            chk("wren", dtw_fifo_wren, (exp_q.size() != 0) && !dtw_fifo_full);
            if (dtw_fifo_wren) begin
                b = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
                chk("din", dtw_fifo_din, b);
                log_q.push_back(dtw_fifo_din);
                cyc_q.push_back(cyc);
            end else begin
                chk("din_idle", dtw_fifo_din, 0);
                if (exp_q.size() != 0) stall_cnt++;
            end
            if (res_valid && res_ready) begin
                accepts++;
                if (!q_open) begin
                    exp_q.push_back(8'hA5);
                    q_open  = 1;
                    q_count = 0;
                    q_xor   = 0;
                end
                for (int i = 0; i < 4; i++) begin
                    b = 8'((res_cost >> (8 * i)) & 32'hFF);
                    exp_q.push_back(b);
                    q_xor ^= b;
                end
                for (int i = 0; i < 2; i++) begin
                    b = 8'((res_pos >> (8 * i)) & 16'hFF);
                    exp_q.push_back(b);
                    q_xor ^= b;
                end
                q_count++;
                if (res_last) begin
                    exp_q.push_back(8'(q_count % 256));
`ifdef DTW_PACKER_CHECKSUM_EN
                    exp_q.push_back(q_xor);
`endif
                    q_open = 0;
                end
            end
        end
    end

    task automatic send(input logic [31:0] c, input logic [15:0] p, input logic l, input bit keep);
        bit acc;
        acc = 0;
        @(posedge ACLK); #1;
        res_cost  = c;
        res_pos   = p;
        res_last  = l;
        res_valid = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            @(negedge ACLK);
            if (res_ready) begin
                acc = 1;
                break;
            end
        end
        @(posedge ACLK); #1;
        if (!keep) res_valid = 1'b0;
        if (!acc) timeout_fail("send_accept");
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 0;
        for (int k = 0; k < 20000; k++) begin
            @(posedge ACLK);
            if (exp_q.size() == 0) begin
                ok = 1;
                break;
            end
        end
        if (!ok) timeout_fail(name);
    endtask

    task automatic wait_log(input int n, input string name);
        bit ok;
        ok = 0;
        for (int k = 0; k < 200; k++) begin
            @(posedge ACLK);
            if (log_q.size() >= n) begin
                ok = 1;
                break;
            end
        end
        if (!ok) timeout_fail(name);
    endtask

    task automatic chk_frame1(input string name);
        logic [7:0] e[$];
        e = '{8'hA5, 8'h44, 8'h33, 8'h22, 8'h11, 8'h66, 8'h55, 8'h01};
`ifdef DTW_PACKER_CHECKSUM_EN
        e.push_back(8'h77);
`endif
        chk({name, "_len"}, log_q.size(), e.size());
        for (int i = 0; i < e.size(); i++) chk(name, log_q[i], e[i]);
    endtask

    initial begin
        ARESET        = 1'b1;
        res_valid     = 1'b0;
        res_cost      = '0;
        res_pos       = '0;
        res_last      = 1'b0;
        dtw_fifo_full = 1'b0;
        repeat (3) @(posedge ACLK);
        #1 ARESET = 1'b0;
        @(negedge ACLK);
        chk("ready_after_reset", res_ready, 1);
        chk("wren_after_reset", dtw_fifo_wren, 0);

        // Single result, no backpressure: literal frame on consecutive cycles
        log_q.delete(); cyc_q.delete();
        send(32'h11223344, 16'h5566, 1'b1, 0);
        wait_idle("t1_idle");
        chk_frame1("t1_byte");
        chk("t1_consecutive", cyc_q[cyc_q.size() - 1] - cyc_q[0], 7 + TAIL - 1);

        // Three results in one query
        log_q.delete();
        send($urandom, 16'($urandom), 1'b0, 0);
        send($urandom, 16'($urandom), 1'b0, 0);
        send($urandom, 16'($urandom), 1'b1, 0);
        wait_idle("t2_idle");
        chk("t2_len", log_q.size(), 1 + 18 + TAIL);
        chk("t2_hdr", log_q[0], 8'hA5);
        chk("t2_trl", log_q[19], 8'h03);

        // Five-cycle stall on payload byte 3
        log_q.delete(); stall_cnt = 0;
        fork
            send(32'h11223344, 16'h5566, 1'b1, 0);
            begin
                wait_log(4, "t3_wait");
                #1 dtw_fifo_full = 1'b1;
                repeat (5) @(posedge ACLK);
                #1 dtw_fifo_full = 1'b0;
            end
        join
        wait_idle("t3_idle");
        chk("t3_stall_cycles", stall_cnt, 5);
        chk_frame1("t3_byte");

        // 256 results wrap the count to zero, next query counts from one
        log_q.delete();
        for (int i = 0; i < 256; i++) send($urandom, 16'($urandom), 1'(i == 255), 0);
        wait_idle("t4_idle");
        chk("t4_len", log_q.size(), 1 + 256 * 6 + TAIL);
        chk("t4_trl", log_q[log_q.size() - TAIL], 8'h00);
        log_q.delete();
        send($urandom, 16'($urandom), 1'b1, 0);
        wait_idle("t4b_idle");
        chk("t4b_trl", log_q[log_q.size() - TAIL], 8'h01);

        // Reset after three payload bytes abandons the frame
        log_q.delete();
        send(32'hDEADBEEF, 16'hCAFE, 1'b1, 0);
        wait_log(4, "t5_wait");
        #1 ARESET = 1'b1;
        @(posedge ACLK); #1 ARESET = 1'b0;
        @(negedge ACLK);
        chk("t5_ready_post_reset", res_ready, 1);
        chk("t5_len_abandoned", log_q.size(), 4);
        log_q.delete();
        send(32'h11223344, 16'h5566, 1'b1, 0);
        wait_idle("t5_idle");
        chk_frame1("t5_byte");

        // Valid held high across two queued results
        log_q.delete(); accepts = 0;
        send(32'h01020304, 16'h0506, 1'b0, 1);
        send(32'h0A0B0C0D, 16'h0E0F, 1'b1, 0);
        wait_idle("t6_idle");
        chk("t6_accepts", accepts, 2);
        chk("t6_len", log_q.size(), 1 + 12 + TAIL);
        chk("t6_trl", log_q[13], 8'h02);

        // Randomized queries with random backpressure and valid gaps
        full_mode = 1;
        for (int q = 0; q < 30; q++) begin
            int n;
            n = $urandom_range(1, 5);
            for (int r = 0; r < n; r++) begin
                repeat ($urandom_range(0, 3)) @(posedge ACLK);
                send($urandom, 16'($urandom), 1'(r == n - 1), 0);
            end
        end
        wait_idle("t7_idle");
        full_mode = 0;
        @(posedge ACLK); #1 dtw_fifo_full = 1'b0;
        repeat (3) @(posedge ACLK);
        chk("t7_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
